// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone B4 classic arbiter.
// Grants whole CYC-framed cycles round-robin; a per-grant watchdog
// aborts a stalled strobe with a one-cycle ERR to the owning master.
module wb_arbiter2 #(
  parameter int unsigned ADR_W   = 32,
  parameter int unsigned DAT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // master 0 (instruction bus)
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [ADR_W-1:0]     m0_adr,
  input  logic [DAT_W/8-1:0]   m0_sel,
  input  logic [DAT_W-1:0]     m0_dat_w,
  output logic [DAT_W-1:0]     m0_dat_r,
  output logic                 m0_ack,
  output logic                 m0_err,
  // master 1 (data bus)
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [ADR_W-1:0]     m1_adr,
  input  logic [DAT_W/8-1:0]   m1_sel,
  input  logic [DAT_W-1:0]     m1_dat_w,
  output logic [DAT_W-1:0]     m1_dat_r,
  output logic                 m1_ack,
  output logic                 m1_err,
  // shared slave
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [ADR_W-1:0]     s_adr,
  output logic [DAT_W/8-1:0]   s_sel,
  output logic [DAT_W-1:0]     s_dat_w,
  input  logic [DAT_W-1:0]     s_dat_r,
  input  logic                 s_ack,
  output logic [1:0]           grant
);

  localparam int unsigned SEL_W = DAT_W / 8;
  // Keep at least one bit so TIMEOUT=0 (watchdog disabled) still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;   // last granted master; also the owner in OWNx/ABORT
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own_cyc, own_stb;

  // Read data is qualified only by ack, so it is broadcast to both masters.
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration, slave mux, response routing and watchdog next-state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = SEL_W'(0);
    s_dat_w = '0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_err  = 1'b0;
    grant   = 2'b00;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (m1_cyc) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0: begin
        grant   = 2'b01;
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_sel   = m0_sel;
        s_dat_w = m0_dat_w;
        m0_ack  = s_ack;
        own_cyc = m0_cyc;
        own_stb = m0_stb;
      end
      OWN1: begin
        grant   = 2'b10;
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_sel   = m1_sel;
        s_dat_w = m1_dat_w;
        m1_ack  = s_ack;
        own_cyc = m1_cyc;
        own_stb = m1_stb;
      end
      ABORT: begin
        grant   = last_q ? 2'b10 : 2'b01;
        m0_err  = !last_q;
        m1_err  = last_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Watchdog: ack restarts it, a waiting strobe advances it; abort once
    // the count reaches TIMEOUT. Dropping CYC always releases without error.
    if (state_q == OWN0 || state_q == OWN1) begin
      if (s_ack) begin
        cnt_d = '0;
      end else if (own_stb && TIMEOUT != 0) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (!own_cyc) begin
        state_d = IDLE;
      end else if (TIMEOUT != 0 && !s_ack && own_stb && cnt_d == CNT_MAX) begin
        state_d = ABORT;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2 (TIMEOUT=4): reset, vector table,
// directed data/reset/fairness sequences, then random traffic vs a model.
module tb_wb_arbiter2;

  localparam int unsigned TMO = 4;

  logic        clk;
  logic        rst;
  logic        mc[2], ms[2], mw[2];
  logic [31:0] ma[2], md[2];
  logic [3:0]  msel[2];
  logic        sack;
  logic [31:0] sdr;

  logic [31:0] m0_dat_r, m1_dat_r, s_adr, s_dat_w;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  // model state: current owner / aborting master (-1 = none)
  int m_own, m_err, m_last, m_stall;

  wb_arbiter2 #(.ADR_W(32), .DAT_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(mc[0]), .m0_stb(ms[0]), .m0_we(mw[0]), .m0_adr(ma[0]), .m0_sel(msel[0]),
    .m0_dat_w(md[0]), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(mc[1]), .m1_stb(ms[1]), .m1_we(mw[1]), .m1_adr(ma[1]), .m1_sel(msel[1]),
    .m1_dat_w(md[1]), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_w(s_dat_w), .s_dat_r(sdr), .s_ack(sack), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // vector table: in = {c0,s0,c1,s1,ack}; out = {scyc,sstb,ack0,ack1,err0,err1}
  typedef struct packed {
    logic [4:0] in;
    logic [1:0] g;
    logic [5:0] out;
  } vec_t;
  vec_t tbl[16];

  // Reference model: expected outputs from owner/abort bookkeeping.
  task automatic model_check();
    logic [1:0]  eg;
    logic        ecyc, estb, ewe, ea0, ea1, ee0, ee1;
    logic [31:0] eadr, edat;
    logic [3:0]  esel;
    eg = 2'b00; ecyc = 0; estb = 0; ewe = 0; ea0 = 0; ea1 = 0; ee0 = 0; ee1 = 0;
    eadr = '0; edat = '0; esel = '0;
    if (m_err >= 0) begin
      eg  = (m_err == 0) ? 2'b01 : 2'b10;
      ee0 = (m_err == 0);
      ee1 = (m_err == 1);
    end else if (m_own >= 0) begin
      eg   = (m_own == 0) ? 2'b01 : 2'b10;
      ecyc = mc[m_own]; estb = ms[m_own]; ewe = mw[m_own];
      eadr = ma[m_own]; esel = msel[m_own]; edat = md[m_own];
      ea0  = (m_own == 0) && sack;
      ea1  = (m_own == 1) && sack;
    end
    chk("rnd grant", 32'(grant), 32'(eg));
    chk("rnd s_cyc", 32'(s_cyc), 32'(ecyc));
    chk("rnd s_stb", 32'(s_stb), 32'(estb));
    chk("rnd s_we", 32'(s_we), 32'(ewe));
    chk("rnd s_adr", s_adr, eadr);
    chk("rnd s_sel", 32'(s_sel), 32'(esel));
    chk("rnd s_dat_w", s_dat_w, edat);
    chk("rnd m0_ack", 32'(m0_ack), 32'(ea0));
    chk("rnd m1_ack", 32'(m1_ack), 32'(ea1));
    chk("rnd m0_err", 32'(m0_err), 32'(ee0));
    chk("rnd m1_err", 32'(m1_err), 32'(ee1));
    chk("rnd m0_dat_r", m0_dat_r, sdr);
    chk("rnd m1_dat_r", m1_dat_r, sdr);
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    int w;
    if (m_err >= 0) begin
      m_err = -1;
    end else if (m_own >= 0) begin
      if (!mc[m_own]) m_own = -1;
      else if (sack) m_stall = 0;
      else if (ms[m_own]) begin
        m_stall++;
        if (m_stall == int'(TMO)) begin
          m_err = m_own;
          m_own = -1;
        end
      end
    end else begin
      m_stall = 0;
      if (mc[0] && mc[1]) w = 1 - m_last;
      else if (mc[0]) w = 0;
      else if (mc[1]) w = 1;
      else w = -1;
      if (w >= 0) begin
        m_own  = w;
        m_last = w;
      end
    end
  endtask

  initial begin
    int          nrec;
    logic [1:0]  exp_g;
    logic        a0, a1;

    tbl[0]  = '{5'b11110, 2'b00, 6'b000000};
    tbl[1]  = '{5'b11111, 2'b01, 6'b111000};
    tbl[2]  = '{5'b00110, 2'b01, 6'b000000};
    tbl[3]  = '{5'b00110, 2'b00, 6'b000000};
    tbl[4]  = '{5'b11111, 2'b10, 6'b110100};
    tbl[5]  = '{5'b11000, 2'b10, 6'b000000};
    tbl[6]  = '{5'b11000, 2'b00, 6'b000000};
    tbl[7]  = '{5'b11110, 2'b01, 6'b110000};
    tbl[8]  = '{5'b11110, 2'b01, 6'b110000};
    tbl[9]  = '{5'b11110, 2'b01, 6'b110000};
    tbl[10] = '{5'b11110, 2'b01, 6'b110000};
    tbl[11] = '{5'b11110, 2'b01, 6'b000010};
    tbl[12] = '{5'b11110, 2'b00, 6'b000000};
    tbl[13] = '{5'b11111, 2'b10, 6'b110100};
    tbl[14] = '{5'b11000, 2'b10, 6'b000000};
    tbl[15] = '{5'b00000, 2'b00, 6'b000000};

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; ms[i] = 0; mw[i] = 0; ma[i] = '0; md[i] = '0; msel[i] = '0;
    end
    sack = 0; sdr = 32'h0;

    // asynchronous reset, no clock edge yet
    #3;
    rst = 1'b0;
    mc[0] = 1; ms[0] = 1; mw[0] = 1; ma[0] = 32'h10; msel[0] = 4'hF;
    mc[1] = 1; ms[1] = 1; sack = 1;
    #1;
    chk("rst grant", 32'(grant), 32'(2'b00));
    chk("rst s_cyc", 32'(s_cyc), 32'(1'b0));
    chk("rst s_stb", 32'(s_stb), 32'(1'b0));
    chk("rst s_we", 32'(s_we), 32'(1'b0));
    chk("rst s_adr", s_adr, 32'h0);
    chk("rst s_sel", 32'(s_sel), 32'h0);
    chk("rst m0_ack", 32'(m0_ack), 32'(1'b0));
    chk("rst m1_ack", 32'(m1_ack), 32'(1'b0));
    chk("rst m0_err", 32'(m0_err), 32'(1'b0));
    chk("rst m1_err", 32'(m1_err), 32'(1'b0));
    next_cycle();
    next_cycle();
    rst = 1'b1;
    mw[0] = 0; ma[1] = 32'h100;

    // vector table: tie, release dead cycle, alternation, watchdog abort
    for (int i = 0; i < 16; i++) begin
      {mc[0], ms[0], mc[1], ms[1], sack} = tbl[i].in;
      @(negedge clk);
      chk($sformatf("tbl%0d grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("tbl%0d s_cyc", i), 32'(s_cyc), 32'(tbl[i].out[5]));
      chk($sformatf("tbl%0d s_stb", i), 32'(s_stb), 32'(tbl[i].out[4]));
      chk($sformatf("tbl%0d m0_ack", i), 32'(m0_ack), 32'(tbl[i].out[3]));
      chk($sformatf("tbl%0d m1_ack", i), 32'(m1_ack), 32'(tbl[i].out[2]));
      chk($sformatf("tbl%0d m0_err", i), 32'(m0_err), 32'(tbl[i].out[1]));
      chk($sformatf("tbl%0d m1_err", i), 32'(m1_err), 32'(tbl[i].out[0]));
      next_cycle();
    end

    // single read by m0 at 0x10
    ma[0] = 32'h10; mw[0] = 0; msel[0] = 4'hF; mc[0] = 1; ms[0] = 1;
    @(negedge clk);
    chk("rd idle grant", 32'(grant), 32'(2'b00));
    next_cycle();
    sack = 1; sdr = 32'h1234_5678;
    @(negedge clk);
    chk("rd grant", 32'(grant), 32'(2'b01));
    chk("rd s_adr", s_adr, 32'h10);
    chk("rd s_we", 32'(s_we), 32'(1'b0));
    chk("rd m0_ack", 32'(m0_ack), 32'(1'b1));
    chk("rd m0_dat_r", m0_dat_r, 32'h1234_5678);
    chk("rd m1_ack", 32'(m1_ack), 32'(1'b0));
    next_cycle();
    mc[0] = 0; ms[0] = 0; sack = 0;
    next_cycle();
    @(negedge clk);
    chk("rd release grant", 32'(grant), 32'(2'b00));

    // m1 write routing while m0 drives junk without CYC
    ma[0] = 32'hFFFF_FFFF; md[0] = 32'h5555_5555; mw[0] = 0; msel[0] = 4'h3;
    ma[1] = 32'h100; md[1] = 32'hDEAD_BEEF; mw[1] = 1; msel[1] = 4'b1100;
    mc[1] = 1; ms[1] = 1;
    next_cycle();
    sack = 1;
    @(negedge clk);
    chk("wr grant", 32'(grant), 32'(2'b10));
    chk("wr s_we", 32'(s_we), 32'(1'b1));
    chk("wr s_sel", 32'(s_sel), 32'(4'b1100));
    chk("wr s_dat_w", s_dat_w, 32'hDEAD_BEEF);
    chk("wr s_adr", s_adr, 32'h100);
    chk("wr m1_ack", 32'(m1_ack), 32'(1'b1));
    chk("wr m0_ack", 32'(m0_ack), 32'(1'b0));
    next_cycle();
    mc[1] = 0; ms[1] = 0; mw[1] = 0; sack = 0;
    next_cycle();

    // async reset while m1 owns and is stalled
    mc[1] = 1; ms[1] = 1;
    next_cycle();
    @(negedge clk);
    chk("ar pre grant", 32'(grant), 32'(2'b10));
    chk("ar pre s_cyc", 32'(s_cyc), 32'(1'b1));
    sack = 1;
    rst = 1'b0;
    #1;
    chk("ar s_cyc", 32'(s_cyc), 32'(1'b0));
    chk("ar s_stb", 32'(s_stb), 32'(1'b0));
    chk("ar grant", 32'(grant), 32'(2'b00));
    chk("ar m1_ack", 32'(m1_ack), 32'(1'b0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1; sack = 1;

    // fairness: both keep requesting; owner drops CYC for one cycle after ack
    nrec = 0;
    for (int k = 0; k < 40 && nrec < 6; k++) begin
      @(negedge clk);
      if (s_cyc) begin
        exp_g = (nrec % 2 == 0) ? 2'b01 : 2'b10;
        chk($sformatf("fair%0d grant", nrec), 32'(grant), 32'(exp_g));
        nrec++;
      end
      a0 = m0_ack;
      a1 = m1_ack;
      next_cycle();
      mc[0] = !(a0 && mc[0]); ms[0] = mc[0];
      mc[1] = !(a1 && mc[1]); ms[1] = mc[1];
    end
    chk("fair count", 32'(nrec), 32'd6);

    // random traffic against the reference model
    mc[0] = 0; ms[0] = 0; mc[1] = 0; ms[1] = 0; sack = 0;
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    m_own = -1; m_err = -1; m_last = 1; m_stall = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int x = 0; x < 2; x++) begin
        if (mc[x]) begin
          if ($urandom_range(7) == 0) mc[x] = 0;
        end else if ($urandom_range(2) == 0) begin
          mc[x] = 1;
        end
        ms[x]   = mc[x] ? ($urandom_range(3) != 0) : 1'($urandom_range(1));
        mw[x]   = 1'($urandom_range(1));
        ma[x]   = $urandom();
        md[x]   = $urandom();
        msel[x] = 4'($urandom_range(15));
      end
      sack = ($urandom_range(3) == 0);
      sdr  = $urandom();
      @(negedge clk);
      model_check();
      model_step();
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone B4 (classic cycle) arbiter that lets the core's instruction bus and data bus share a single `ram_wb` memory or other slave. It sits between `core` and the shared slave. It grants whole bus cycles (CYC-framed) using round-robin priority. A per-grant watchdog terminates stalled transfers with ERR.

## Interface
- `ADR_W`, 32: address width.
- `DAT_W`, 32: data width; `SEL_W = DAT_W/8`.
- `TIMEOUT`, 255: maximum cycles STB may wait for ACK. 0 disables the watchdog.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `m0_cyc, m0_stb, m0_we`  in  1 each  master 0 (instruction bus) requests.
- `m0_adr`  in  ADR_W; `m0_sel`  in  SEL_W; `m0_dat_w`  in  DAT_W  master 0 write data.
- `m0_dat_r`  out  DAT_W; `m0_ack`, `m0_err`  out  1  master 0 responses.
- `m1_*`  same set as m0  master 1 (data bus).
- `s_cyc, s_stb, s_we`  out  1; `s_adr`  out  ADR_W; `s_sel`  out  SEL_W; `s_dat_w`  out  DAT_W  to slave.
- `s_dat_r`  in  DAT_W; `s_ack`  in  1  from slave.
- `grant`  out  2  one-hot current owner; 00 = idle.

## Operation
- FSM states: IDLE, OWN0, OWN1, ABORT.
- IDLE:
  - Only `m0_cyc` high → OWN0.
  - Only `m1_cyc` high → OWN1.
  - Both high → the master other than `last` wins.
  - Neither high → stay in IDLE.
- On entering OWNx, `last` <= x.
- OWNx:
  - Slave outputs are a combinational mux of master x.
  - `s_ack` routes only to `mx_ack`, and `s_dat_r` routes to `mx_dat_r`.
  - The other master sees ack=0 and err=0. `m*_dat_r` returns `s_dat_r` unconditionally, since only ack qualifies it.
  - `mx_cyc` low → IDLE.
  - Watchdog expiry → ABORT.
- ABORT:
  - `mx_err` = 1 for exactly one cycle.
  - `s_cyc` = `s_stb` = 0.
  - Next state is IDLE unconditionally.
- Watchdog counter, width $clog2(TIMEOUT+1):
  - Clears in IDLE and on any cycle with `s_ack`=1.
  - Increments in OWNx while `mx_stb`=1 and `s_ack`=0.
  - Holds while `mx_stb`=0.
  - Expiry is counter == TIMEOUT with `s_ack`=0. When TIMEOUT=0 there is no expiry.
- In IDLE and ABORT, `s_cyc`, `s_stb` and `s_we` are 0, and `s_adr`, `s_sel` and `s_dat_w` are 0.
- `grant` = 01 in OWN0 and ABORT-from-0, 10 in OWN1 and ABORT-from-1, 00 in IDLE.
- A master that drops CYC mid-wait, with STB pending and no ACK, releases the bus. The FSM goes to IDLE and no error is raised.

## Timing
- Reset (rst=0), effective immediately and asynchronously:
  - state=IDLE, `last`=1 (so m0 wins the first tie), counter=0.
  - `grant`=00; all `s_*` outputs and `m*_ack`/`m*_err` are 0.
- Reset asserted mid-transfer: outputs drop in the same time step. The slave sees CYC fall, and the master gets no ACK.
- Arbitration latency: request at edge N (cyc sampled high) → OWNx from edge N+1. The slave sees `s_cyc`/`s_stb` in cycle N+1.
- Data-path latency: zero. ACK and read data are combinational slave→master in the OWN state.
- Release: `mx_cyc` sampled low at edge K → IDLE after K. Earliest next grant is after edge K+1, giving one dead cycle between owners.
- Back-to-back contention alternates owners: m0, m1, m0, ...
- Pipelined/burst masters hold CYC across multiple STB/ACK pairs and keep ownership throughout. Each ACK restarts the watchdog.
- Timeout with TIMEOUT=T: STB raised in the first OWN cycle and never acked → counter reaches T after T cycles. ABORT (err pulse) follows in cycle T+1 of ownership, then IDLE.

## Test plan
- Single read: m0 reads 0x0000_0010 with no contention → grant=01 one cycle after cyc. The slave sees adr 0x10. `m0_ack` and `m0_dat_r` match the slave in the same cycle. grant=00 one cycle after cyc drops.
- Simultaneous first request: m0 and m1 raise cyc on the same edge out of reset → m0 owns first. m1 owns after m0 releases plus one IDLE cycle. `m1_ack` stays 0 during m0 ownership.
- Fairness: both masters hold requests continuously for 6 transactions → grant sequence 01,10,01,10,01,10. Neither master is starved.
- Write routing: m1 writes 0xDEAD_BEEF with sel=1100 to 0x0000_0100 → `s_we`=1, `s_sel`=1100, `s_dat_w`=0xDEADBEEF. m0 outputs are ignored during the transfer.
- Watchdog: TIMEOUT=4 and the slave never acks m0 → exactly one `m0_err` pulse in the 5th ownership cycle, `s_cyc` low in that cycle, then IDLE. A pending m1 is granted next.
- Async reset mid-transfer: rst=0 while OWN1 and stalled → `s_cyc`, `s_stb` and grant go to 0 immediately. After release the FSM is in IDLE with `last`=1, so a tie grants m0.
